// File: rtl/finger_dancer_pkg.sv
// Shared constants and types for the finger-dancer rhythm game blocks.
// Holds the judge FSM encoding, the default judgement window and finger count.
package finger_dancer_pkg;

    localparam int NUM_FINGERS    = 4;
    localparam int WINDOW_DEFAULT = 8;
    localparam int COMBO_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_RESULT = 2'd2
    } judge_state_t;

    // Saturating increment for the hit-run counter.
    function automatic logic [COMBO_W-1:0] combo_inc(input logic [COMBO_W-1:0] value);
        return (value == '1) ? value : value + COMBO_W'(1);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the finger buttons: a press is "high now, low last cycle".
// The history register tracks KEYS every cycle regardless of what the judge is doing.
module key_edge_detect
    import finger_dancer_pkg::*;
(
    input  logic                   C,
    input  logic                   INIT,
    input  logic [NUM_FINGERS-1:0] KEYS,
    output logic [NUM_FINGERS-1:0] PRESS
);

    logic [NUM_FINGERS-1:0] prev_keys;

    // NOTE: registers are written with <= so every flop samples the pre-edge value.
    always_ff @(posedge C) begin
        if (INIT) begin
            prev_keys <= '0;
        end else begin
            prev_keys <= KEYS;
        end
    end

    assign PRESS = KEYS & ~prev_keys;

endmodule

// File: rtl/note_judge.sv
// Judges one offered note at a time: collects finger presses inside a TICK-counted
// window and emits a one-cycle HIT or MISS, keeping a combo run and a score.
module note_judge
    import finger_dancer_pkg::*;
#(
    parameter int WINDOW  = WINDOW_DEFAULT,
    parameter int SCORE_W = 16
) (
    input  logic                   C,
    input  logic                   INIT,
    input  logic                   TICK,
    input  logic [NUM_FINGERS-1:0] KEYS,
    input  logic                   NOTE_VALID,
    input  logic [NUM_FINGERS-1:0] NOTE,
    output logic                   NOTE_READY,
    output logic                   HIT,
    output logic                   MISS,
    output logic [COMBO_W-1:0]     COMBO,
    output logic [SCORE_W-1:0]     SCORE
);

    localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

    judge_state_t           state;
    logic [NUM_FINGERS-1:0] target;
    logic [NUM_FINGERS-1:0] pressed;
    logic [NUM_FINGERS-1:0] press;
    logic [NUM_FINGERS-1:0] pressed_next;
    logic [7:0]             win_cnt;
    logic                   wrong_key;
    logic                   full_match;
    logic                   expired;

    key_edge_detect u_edge (
        .C     (C),
        .INIT  (INIT),
        .KEYS  (KEYS),
        .PRESS (press)
    );

    // Verdict inputs include this cycle's presses so a completing press is judged at once.
    assign pressed_next = pressed | press;
    assign wrong_key    = (pressed_next & ~target) != '0;
    assign full_match   = (pressed_next == target);
    assign expired      = TICK && (win_cnt == WIN_LAST);

    assign NOTE_READY   = (state == ST_IDLE);

    always_ff @(posedge C) begin
        if (INIT) begin
            state   <= ST_IDLE;
            target  <= '0;
            pressed <= '0;
            win_cnt <= '0;
            HIT     <= 1'b0;
            MISS    <= 1'b0;
            COMBO   <= '0;
            SCORE   <= '0;
        end else begin
            // Pulses default low; they are only raised on the edge that enters RESULT.
            HIT  <= 1'b0;
            MISS <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (NOTE_VALID && (NOTE != '0)) begin
                        state   <= ST_OPEN;
                        target  <= NOTE;
                        pressed <= '0;
                        win_cnt <= '0;
                    end
                end
                ST_OPEN: begin
                    pressed <= pressed_next;
                    if (wrong_key || (!full_match && expired)) begin
                        state <= ST_RESULT;
                        MISS  <= 1'b1;
                        COMBO <= '0;
                    end else if (full_match) begin
                        state <= ST_RESULT;
                        HIT   <= 1'b1;
                        COMBO <= combo_inc(COMBO);
                        SCORE <= (SCORE == '1) ? SCORE : SCORE + SCORE_W'(1);
                    end else if (TICK) begin
                        win_cnt <= win_cnt + 8'd1;
                    end
                end
                ST_RESULT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
